tmp100_poll_ctrl: RTL and testbench

Sequencer for the TMP100 I2C transaction engine (i2c_tmp100). After reset it waits for sensor power-up, issues one configuration write, then polls the temperature register periodically or on demand. It extracts the 12-bit signed temperature, flags timeouts with bounded retry and re-configuration, and drives an over-temperature alarm with hysteresis. It sits between the board-management logic and the I2C engine, in the engine's input clock domain.

---
 rtl/tmp100_poll_ctrl.sv | 128 ++++++++++++
 tb/tb_tmp100_poll_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tmp100_poll_ctrl.sv
// tmp100_poll_ctrl: powers up, configures and periodically reads a TMP100 through the i2c_tmp100 engine,
// with bounded read retry, timeout reporting and a hysteretic over-temperature alarm.
module tmp100_poll_ctrl #(
  parameter logic        [15:0] POWERUP_CYC = 16'd4000,
  parameter logic        [23:0] POLL_CYC    = 24'd40000,
  parameter logic        [15:0] TIMEOUT_CYC = 16'd255,
  parameter logic        [3:0]  STAT_HOLD   = 4'd4,
  parameter logic        [7:0]  CFG_GROUPS  = 8'd4,
  parameter logic        [7:0]  RD_GROUPS   = 8'd2,
  parameter logic        [2:0]  MAX_RETRY   = 3'd3,
  parameter logic signed [11:0] T_HIGH      = 12'sh500,
  parameter logic signed [11:0] T_LOW       = 12'sh4B0
) (
  input  logic        i2c_clk_in,
  input  logic        i2c_rst_n_in,
  input  logic        poll_en,
  input  logic        rd_req,
  output logic        i2c_wr_rd,
  output logic [7:0]  group_number,
  output logic        i2c_stat,
  input  logic        i2c_wend,
  input  logic        i2c_rd_valid,
  input  logic [15:0] i2c_reg_out,
  output logic [11:0] temp_out,
  output logic        temp_valid,
  output logic        temp_alarm,
  output logic        i2c_err,
  output logic [7:0]  err_cnt,
  output logic        busy
);
  localparam logic [2:0] PWRUP     = 3'd0;
  localparam logic [2:0] CFG_START = 3'd1;
  localparam logic [2:0] CFG_WAIT  = 3'd2;
  localparam logic [2:0] POLL_WAIT = 3'd3;
  localparam logic [2:0] RD_START  = 3'd4;
  localparam logic [2:0] RD_WAIT   = 3'd5;
  logic [2:0] state;
  logic [15:0] pwr_cnt;
  logic [15:0] tcnt;
  logic [23:0] pcnt;
  logic [3:0] hcnt;
  logic [2:0] retry;
  logic wend_q;
  logic rdv_q;
  logic wend_edge;
  logic rdv_edge;
  logic tmo_hit;
  logic last_try;
  logic go_cfg;
  logic go_rd;
  logic signed [11:0] temp_new;
  logic unused_lsb;
  assign unused_lsb = ^i2c_reg_out[3:0];
  assign temp_new = i2c_reg_out[15:4];
  assign wend_edge = i2c_wend & ~wend_q;
  assign rdv_edge = i2c_rd_valid & ~rdv_q;
  // a completion edge in the timeout cycle takes priority over the timeout
  assign tmo_hit = (tcnt + 16'd1 == TIMEOUT_CYC) && (state == CFG_WAIT ? !wend_edge : state == RD_WAIT && !rdv_edge);
  assign last_try = retry + 3'd1 == MAX_RETRY;
  assign go_cfg = (state == PWRUP && pwr_cnt == POWERUP_CYC - 16'd1) || (tmo_hit && (state == CFG_WAIT || last_try));
  assign go_rd = (state == POLL_WAIT && (rd_req || (poll_en && pcnt == POLL_CYC - 24'd1))) ||
                 (tmo_hit && state == RD_WAIT && !last_try);
  assign busy = state != POLL_WAIT;
  always_ff @(posedge i2c_clk_in or negedge i2c_rst_n_in)
    if (!i2c_rst_n_in) begin
      state <= PWRUP;
      pwr_cnt <= 16'd0;
      tcnt <= 16'd0;
      pcnt <= 24'd0;
      hcnt <= 4'd0;
      retry <= 3'd0;
      wend_q <= 1'b0;
      rdv_q <= 1'b0;
      i2c_wr_rd <= 1'b0;
      group_number <= 8'd0;
      i2c_stat <= 1'b0;
      temp_out <= 12'd0;
      temp_valid <= 1'b0;
      temp_alarm <= 1'b0;
      i2c_err <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      wend_q <= i2c_wend;
      rdv_q <= i2c_rd_valid;
      temp_valid <= 1'b0;
      i2c_err <= 1'b0;
      tcnt <= tcnt + 16'd1;
      case (state)
        PWRUP: pwr_cnt <= pwr_cnt + 16'd1;
        CFG_START, RD_START:
          if (hcnt == STAT_HOLD - 4'd1) begin
            i2c_stat <= 1'b0;
            state <= state == CFG_START ? CFG_WAIT : RD_WAIT;
          end else hcnt <= hcnt + 4'd1;
        CFG_WAIT:
          if (wend_edge) begin
            retry <= 3'd0;
            pcnt <= 24'd0;
            state <= POLL_WAIT;
          end
        POLL_WAIT: pcnt <= poll_en ? pcnt + 24'd1 : 24'd0;
        RD_WAIT:
          if (rdv_edge) begin
            temp_out <= temp_new;
            temp_valid <= 1'b1;
            temp_alarm <= temp_new >= T_HIGH ? 1'b1 : temp_new < T_LOW ? 1'b0 : temp_alarm;
            retry <= 3'd0;
            pcnt <= 24'd0;
            state <= POLL_WAIT;
          end
        default: state <= PWRUP;
      endcase
      if (tmo_hit) begin
        i2c_err <= 1'b1;
        err_cnt <= err_cnt + {7'd0, err_cnt != 8'hFF};
        retry <= state == RD_WAIT && !last_try ? retry + 3'd1 : 3'd0;
      end
      // wr_rd and group_number are only loaded here, so they stay stable until the next start
      if (go_cfg || go_rd) begin
        state <= go_rd ? RD_START : CFG_START;
        i2c_wr_rd <= go_rd;
        group_number <= go_rd ? RD_GROUPS : CFG_GROUPS;
        i2c_stat <= 1'b1;
        hcnt <= 4'd0;
        tcnt <= 16'd0;
      end
    end
endmodule

// File: tb/tb_tmp100_poll_ctrl.sv
// tb_tmp100_poll_ctrl: directed bench for tmp100_poll_ctrl with shortened power-up, poll and timeout periods.
module tb_tmp100_poll_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic poll_en = 1'b0;
  logic rd_req = 1'b0;
  logic i2c_wr_rd;
  logic [7:0] group_number;
  logic i2c_stat;
  logic i2c_wend = 1'b0;
  logic i2c_rd_valid = 1'b0;
  logic [15:0] i2c_reg_out = 16'd0;
  logic [11:0] temp_out;
  logic temp_valid;
  logic temp_alarm;
  logic i2c_err;
  logic [7:0] err_cnt;
  logic busy;
  int checks = 0;
  int errors = 0;
  tmp100_poll_ctrl #(
    .POWERUP_CYC(16'd40),
    .POLL_CYC(24'd100),
    .TIMEOUT_CYC(16'd80)
  ) dut (
    .i2c_clk_in(clk),
    .i2c_rst_n_in(rst_n),
    .poll_en(poll_en),
    .rd_req(rd_req),
    .i2c_wr_rd(i2c_wr_rd),
    .group_number(group_number),
    .i2c_stat(i2c_stat),
    .i2c_wend(i2c_wend),
    .i2c_rd_valid(i2c_rd_valid),
    .i2c_reg_out(i2c_reg_out),
    .temp_out(temp_out),
    .temp_valid(temp_valid),
    .temp_alarm(temp_alarm),
    .i2c_err(i2c_err),
    .err_cnt(err_cnt),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_stat(input int max, output int n);
    n = 0;
    while (i2c_stat !== 1'b1 && n < max) begin
      step();
      n++;
    end
  endtask
  task automatic do_read(input logic [15:0] val, input int lat);
    repeat (lat) step();
    i2c_rd_valid = 1'b1;
    i2c_reg_out = val;
    step();
  endtask
  task automatic quiet(input string tag, input int len);
    int starts = 0;
    repeat (len) begin
      step();
      if (i2c_stat) starts++;
    end
    chk(tag, starts, 0);
  endtask
  logic [15:0] rd_val [7] = '{16'h1900, 16'hE700, 16'h5000, 16'h4C00, 16'h4B00, 16'h4A00, 16'h4FF0};
  logic [11:0] rd_tmp [7] = '{12'h190, 12'hE70, 12'h500, 12'h4C0, 12'h4B0, 12'h4A0, 12'h4FF};
  logic rd_alm [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  initial begin
    int n;
    int hi;
    poll_en = 1'b1;
    repeat (3) step();
    chk("rst_busy", busy, 1);
    chk("rst_stat", i2c_stat, 0);
    chk("rst_group", group_number, 0);
    chk("rst_temp", temp_out, 0);
    rst_n = 1'b1;
    wait_stat(100, n);
    chk("pwrup_len", n, 40);
    chk("cfg_wr_rd", i2c_wr_rd, 0);
    chk("cfg_group", group_number, 4);
    hi = 0;
    while (i2c_stat && hi < 20) begin
      hi++;
      step();
    end
    chk("cfg_stat_hold", hi, 4);
    repeat (56) step();
    chk("cfg_busy", busy, 1);
    i2c_wend = 1'b1;
    step();
    chk("cfg_done_busy", busy, 0);
    step();
    i2c_wend = 1'b0;
    wait_stat(200, n);
    chk("first_poll", n, 99);
    chk("rd_wr_rd", i2c_wr_rd, 1);
    chk("rd_group", group_number, 2);
    for (int i = 0; i < 7; i++) begin
      do_read(rd_val[i], 20);
      chk("rd_valid", temp_valid, 1);
      chk("rd_temp", temp_out, rd_tmp[i]);
      chk("rd_alarm", temp_alarm, rd_alm[i]);
      chk("rd_busy", busy, 0);
      step();
      i2c_rd_valid = 1'b0;
      chk("rd_valid_pulse", temp_valid, 0);
      wait_stat(200, n);
      chk("poll_period", n, 99);
    end
    for (int a = 1; a <= 3; a++) begin
      n = 0;
      while (!i2c_err && n < 200) begin
        step();
        n++;
      end
      chk("tmo_lat", n, a == 1 ? 80 : 79);
      chk("tmo_err_cnt", err_cnt, a);
      chk("tmo_restart", i2c_stat, 1);
      chk("tmo_wr_rd", i2c_wr_rd, a < 3 ? 1 : 0);
      chk("tmo_group", group_number, a < 3 ? 2 : 4);
      step();
      chk("tmo_err_pulse", i2c_err, 0);
    end
    chk("tmo_alarm_kept", temp_alarm, 0);
    repeat (29) step();
    i2c_wend = 1'b1;
    poll_en = 1'b0;
    step();
    chk("recfg_busy", busy, 0);
    step();
    i2c_wend = 1'b0;
    quiet("poll_off", 150);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("req_start", i2c_stat, 1);
    chk("req_wr_rd", i2c_wr_rd, 1);
    step();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    do_read(16'h5000, 18);
    chk("req_temp", temp_out, 12'h500);
    chk("req_alarm", temp_alarm, 1);
    step();
    i2c_rd_valid = 1'b0;
    quiet("req_dropped", 150);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    repeat (10) step();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("arst_stat", i2c_stat, 0);
    chk("arst_temp", temp_out, 0);
    chk("arst_alarm", temp_alarm, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_wr_rd", i2c_wr_rd, 0);
    chk("arst_group", group_number, 0);
    repeat (3) step();
    rst_n = 1'b1;
    wait_stat(100, n);
    chk("re_pwrup_len", n, 40);
    chk("re_cfg_wr_rd", i2c_wr_rd, 0);
    chk("re_cfg_group", group_number, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
